// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V datapath constants and ALU op codes
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

endpackage

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - combinational 32-bit ALU shared by execute and target calculation
module rv_alu
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_sel,
  output logic [XLEN-1:0] o_y
);

  logic [4:0] w_shamt;

  // Shifts take only the low five bits of B, matching RV32 shift semantics.
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_y = '0;
    case (i_sel)
      ALU_ADD:   o_y = i_a + i_b;
      ALU_SUB:   o_y = i_a - i_b;
      ALU_SLL:   o_y = i_a << w_shamt;
      ALU_SLT:   o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_y = i_a ^ i_b;
      ALU_SRL:   o_y = i_a >> w_shamt;
      ALU_SRA:   o_y = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_y = i_a | i_b;
      ALU_AND:   o_y = i_a & i_b;
      ALU_PASSB: o_y = i_b;
      default:   o_y = '0;
    endcase
  end

endmodule

// File: rtl/fetch_alu_unit.sv
// rtl/fetch_alu_unit.sv - loadable instruction memory, PC+4 adder and ALU
module fetch_alu_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          IMEM_AW    = 8,
  parameter logic [31:0] NOP_WORD   = rv_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] pc_plus4,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic [31:0] alu_in1,
  input  logic [31:0] alu_in2,
  input  logic [3:0]  alu_sel,
  output logic [31:0] alu_out
);

  logic [31:0]        r_mem [IMEM_DEPTH];
  logic [IMEM_AW-1:0] w_ridx;
  logic [IMEM_AW-1:0] w_widx;
  logic               w_pc_in_range;
  logic               w_waddr_in_range;
  logic               w_unused_lsbs;

  assign w_ridx           = pc[IMEM_AW+1:2];
  assign w_widx           = imem_waddr[IMEM_AW+1:2];
  assign w_pc_in_range    = (pc >> (IMEM_AW + 2)) == 32'd0;
  assign w_waddr_in_range = (imem_waddr >> (IMEM_AW + 2)) == 32'd0;
  assign w_unused_lsbs    = ^{pc[1:0], imem_waddr[1:0]};

  // Whole array clears asynchronously so a mid-run reset restores a NOP sled at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        r_mem[i] <= NOP_WORD;
      end
    end else if (imem_we && w_waddr_in_range) begin
      r_mem[w_widx] <= imem_wdata;
    end
  end

  assign inst     = w_pc_in_range ? r_mem[w_ridx] : NOP_WORD;
  assign pc_plus4 = pc + 32'd4;

  rv_alu u_alu (
    .i_a   (alu_in1),
    .i_b   (alu_in2),
    .i_sel (alu_sel),
    .o_y   (alu_out)
  );

endmodule

// File: tb/tb_fetch_alu_unit.sv
// tb/tb_fetch_alu_unit.sv - directed self-checking bench for fetch_alu_unit
module tb_fetch_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] pc_plus4;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;

  int n_vec;
  int n_miss;

  fetch_alu_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .inst       (inst),
    .pc_plus4   (pc_plus4),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic imem_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       tag;
  } alu_vec_t;

  alu_vec_t alu_tab[$];

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst_n      = 1'b1;
    pc         = 32'h0;
    imem_we    = 1'b0;
    imem_waddr = 32'h0;
    imem_wdata = 32'h0;
    alu_in1    = 32'h0;
    alu_in2    = 32'h0;
    alu_sel    = 4'd0;

    // asynchronous reset pulse well away from any rising edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    pc = 32'h0;   #1 chk("rst_inst_0",     inst, 32'h0000_0013);
                     chk("rst_pc4_0",      pc_plus4, 32'h0000_0004);
    pc = 32'h3FC; #1 chk("rst_inst_3fc",   inst, 32'h0000_0013);
                     chk("rst_pc4_3fc",    pc_plus4, 32'h0000_0400);
    pc = 32'h400; #1 chk("rst_inst_400",   inst, 32'h0000_0013);
                     chk("rst_pc4_400",    pc_plus4, 32'h0000_0404);

    imem_write(32'h0, 32'h0050_0093);
    imem_write(32'h4, 32'h00A0_0113);
    pc = 32'h0; #1 chk("fetch_0", inst, 32'h0050_0093);
    pc = 32'h4; #1 chk("fetch_4", inst, 32'h00A0_0113);
    pc = 32'h6; #1 chk("fetch_6", inst, 32'h00A0_0113);

    // read-during-write on the same word
    @(negedge clk);
    pc         = 32'h8;
    imem_we    = 1'b1;
    imem_waddr = 32'h8;
    imem_wdata = 32'hDEAD_BEEF;
    #1 chk("rdw_before_edge", inst, 32'h0000_0013);
    @(posedge clk);
    #1 chk("rdw_after_edge", inst, 32'hDEAD_BEEF);
    imem_we = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("rst_midrun_8", inst, 32'h0000_0013);
    pc = 32'h0; #1 chk("rst_midrun_0", inst, 32'h0000_0013);

    // write attempted while reset is held must not land
    imem_we    = 1'b1;
    imem_waddr = 32'h0;
    imem_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 imem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("we_in_reset", inst, 32'h0000_0013);

    // out-of-range write would alias word 0 if not dropped
    imem_write(32'h400, 32'h1234_5678);
    pc = 32'h0;   #1 chk("oor_alias_0", inst, 32'h0000_0013);
    pc = 32'h400; #1 chk("oor_read",    inst, 32'h0000_0013);
    pc = 32'hFFFF_FFFC; #1 chk("pc4_wrap", pc_plus4, 32'h0000_0000);
                           chk("oor_top",  inst, 32'h0000_0013);

    alu_tab.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  32'h0000_0000, "add_wrap"});
    alu_tab.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 4'd1,  32'hFFFF_FFFE, "sub"});
    alu_tab.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0001, "slt_neg"});
    alu_tab.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 4'd4,  32'h0000_0000, "sltu_big"});
    alu_tab.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 4'd3,  32'h0000_0000, "slt_pos"});
    alu_tab.push_back('{32'h0000_0001, 32'hFFFF_FFFF, 4'd4,  32'h0000_0001, "sltu_small"});
    alu_tab.push_back('{32'h8000_0000, 32'h0000_0024, 4'd2,  32'h0000_0000, "sll"});
    alu_tab.push_back('{32'h8000_0000, 32'h0000_0024, 4'd6,  32'h0800_0000, "srl"});
    alu_tab.push_back('{32'h8000_0000, 32'h0000_0024, 4'd7,  32'hF800_0000, "sra"});
    alu_tab.push_back('{32'h0000_0003, 32'h0000_0021, 4'd2,  32'h0000_0006, "sll_shamt1"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5,  32'hFF00_FF00, "xor"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd8,  32'hFFF0_FFF0, "or"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9,  32'h00F0_00F0, "and"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd10, 32'h0FF0_0FF0, "passb"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd11, 32'h0000_0000, "sel11"});
    alu_tab.push_back('{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd15, 32'h0000_0000, "sel15"});

    foreach (alu_tab[i]) begin
      alu_in1 = alu_tab[i].a;
      alu_in2 = alu_tab[i].b;
      alu_sel = alu_tab[i].sel;
      #1 chk(alu_tab[i].tag, alu_out, alu_tab[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_alu_unit.md
Name: fetch_alu_unit

Overview:
- Combined fetch/execute helper block for the 5-stage RISC-V pipeline.
- Contains three functions:
  - word-addressed instruction memory (IMEM): loadable, combinational read;
  - PC+4 incrementer;
  - 32-bit ALU used for both execute-stage results and branch/jump target calculation.
- Only the IMEM holds state. The ALU and adder are purely combinational.

Parameters:
- IMEM_DEPTH, 256: number of 32-bit instruction words.
- IMEM_AW, 8: word-index width; must equal log2(IMEM_DEPTH).
- NOP_WORD, 32'h0000_0013: reset and fill value (addi x0,x0,0).

Ports:
- clk  in  1  single system clock; IMEM writes occur on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  32  fetch address (byte address).
- inst  out  32  instruction word at pc.
- pc_plus4  out  32  pc + 4.
- imem_we  in  1  IMEM write enable (program load).
- imem_waddr  in  32  byte address of the word to write.
- imem_wdata  in  32  word to write.
- alu_in1  in  32  ALU operand A.
- alu_in2  in  32  ALU operand B.
- alu_sel  in  4  ALU operation select.
- alu_out  out  32  ALU result.

Behaviour:
- Reset
  - While rst_n=0, every IMEM word is forced to NOP_WORD, asynchronously. This applies even mid-operation.
  - Writes are ignored while rst_n=0.
  - Combinational outputs are unaffected by reset except that inst reads NOP_WORD.
- IMEM read
  - Combinational, zero latency.
  - Word index = pc[IMEM_AW+1:2]; pc[1:0] are ignored (no misalignment trap).
  - If pc[31:IMEM_AW+2] is nonzero (out of range), inst = NOP_WORD.
- IMEM write
  - When rst_n=1 and imem_we=1 at a rising clk, mem[imem_waddr[IMEM_AW+1:2]] <= imem_wdata.
  - An out-of-range imem_waddr (upper bits nonzero) is dropped.
  - imem_waddr[1:0] are ignored.
- Read during write, same address: inst shows the old word until the clock edge and the new word immediately after it.
- pc_plus4 = pc + 32'd4, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- ALU: combinational, with op codes:
  - 0 ADD: A+B, modulo 2^32, no carry out.
  - 1 SUB: A-B, modulo 2^32.
  - 2 SLL: A << B[4:0].
  - 3 SLT: signed A<B ? 1 : 0.
  - 4 SLTU: unsigned A<B ? 1 : 0.
  - 5 XOR.
  - 6 SRL: logical A >> B[4:0].
  - 7 SRA: arithmetic A >>> B[4:0].
  - 8 OR.
  - 9 AND.
  - 10 PASSB: out = B (LUI).
  - 11–15: out = 0.
- ALU shift rule: only B[4:0] is used; B[31:5] is ignored.
- The block has no handshake; all outputs settle within the same cycle as their inputs.

Decomposition:
- Shared package (rv_pkg) holds:
  - ALU op localparams (ALU_ADD=4'd0 … ALU_PASSB=4'd10);
  - NOP_WORD;
  - XLEN=32.
- Natural sub-module: rv_alu, the combinational ALU with the op set above. It is instantiated once here and reusable elsewhere (for example, the target adder).
- IMEM array and the +4 adder stay inline.

Test Plan:
- Reset/NOP: pulse rst_n low asynchronously between clock edges, then drive pc = 0x0, 0x3FC, 0x400.
  - inst = 0x00000013 for all three;
  - pc_plus4 = 0x4, 0x400, 0x404.
- Load/fetch: write 0x00500093 at addr 0x0 and 0x00A00113 at addr 0x4; then set pc = 0x0, 0x4, 0x6.
  - inst = 0x00500093, 0x00A00113, 0x00A00113 (low bits ignored).
- Write timing and reset mid-operation:
  - Same-address write of 0xDEADBEEF to 0x8 while pc = 0x8: inst holds the old value before the edge and 0xDEADBEEF after it.
  - Then assert rst_n=0 without a clock edge: inst becomes 0x00000013 immediately.
- Out-of-range: write 0x12345678 to 0x400 (dropped); pc = 0x400 → inst = 0x00000013. pc = 0xFFFFFFFC → pc_plus4 = 0x0.
- ALU arithmetic/compare, all with A=0xFFFFFFFF, B=0x00000001:
  - ADD → 0x0;
  - SUB → 0xFFFFFFFE;
  - SLT → 1;
  - SLTU → 0.
- ALU logic/shift:
  - A=0x80000000, B=0x00000024 (shamt 4): SLL → 0x0; SRL → 0x08000000; SRA → 0xF8000000.
  - A=0xF0F0F0F0, B=0x0FF00FF0: XOR → 0xFF00FF00; OR → 0xFFF0FFF0; AND → 0x00F000F0; PASSB → 0x0FF00FF0; sel=15 → 0x0.
